// File: rtl/nco_clkgen.sv
// Multi-channel phase-accumulator NCO clock generator. Each channel emits a wrap tick and an MSB square wave;
// increments are reprogrammed phase-continuously through a valid/ready port and take effect at the next wrap.
module nco_clkgen #(
  parameter int N_CH = 2,
  parameter int ACC_W = 32,
  parameter logic [ACC_W-1:0] DEFAULT_INC = ACC_W'(32'h05E5F30F),
  parameter int LOCK_CYCLES = 16,
  localparam int CH_W = $clog2(N_CH) + 1,
  localparam int CNT_W = $clog2(LOCK_CYCLES + 1)
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic [N_CH-1:0]   en,
  input  logic              phase_rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  output logic              cfg_err,
  output logic [N_CH-1:0]   tick,
  output logic [N_CH-1:0]   clk_out,
  output logic              locked
);

  localparam logic [CH_W-1:0]  N_CH_L   = CH_W'(N_CH);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CYCLES);

  logic [N_CH-1:0][ACC_W-1:0] acc_q, acc_d;
  logic [N_CH-1:0][ACC_W-1:0] inc_q, inc_d;
  logic [N_CH-1:0][ACC_W-1:0] pend_inc_q, pend_inc_d;
  logic [N_CH-1:0]            pend_q, pend_d;
  logic [N_CH-1:0]            tick_q, tick_d;
  logic [N_CH-1:0]            clk_out_q, clk_out_d;
  logic [CNT_W-1:0]           lock_cnt_q, lock_cnt_d;
  logic                       locked_q, locked_d;
  logic                       cfg_err_q, cfg_err_d;
  logic                       run_q, run_d;

  logic [ACC_W:0] sum [N_CH];
  logic           ch_busy;
  logic           cfg_bad;
  logic           cfg_fire;
  logic           cfg_accept;

  // Out-of-range channels are never busy, so a bad address still completes its handshake and reports an error.
  always_comb begin
    ch_busy = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (cfg_ch == CH_W'(i)) ch_busy = pend_q[i];
    end
    cfg_ready  = run_q & ~ch_busy;
    cfg_bad    = (cfg_ch >= N_CH_L) | cfg_inc[ACC_W-1];
    cfg_fire   = cfg_valid & cfg_ready;
    cfg_accept = cfg_fire & ~cfg_bad;
    cfg_err_d  = cfg_fire & cfg_bad;
    run_d      = 1'b1;
  end

  always_comb begin
    acc_d      = acc_q;
    inc_d      = inc_q;
    pend_inc_d = pend_inc_q;
    pend_d     = pend_q;
    tick_d     = tick_q;
    clk_out_d  = clk_out_q;
    for (int i = 0; i < N_CH; i++) begin
      sum[i] = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
      if (phase_rst) begin
        acc_d[i]     = '0;
        tick_d[i]    = 1'b0;
        clk_out_d[i] = 1'b0;
      end else if (!en[i]) begin
        acc_d[i]     = '0;
        tick_d[i]    = 1'b0;
        clk_out_d[i] = 1'b0;
        if (pend_q[i]) begin
          inc_d[i]  = pend_inc_q[i];
          pend_d[i] = 1'b0;
        end
      end else begin
        acc_d[i]     = sum[i][ACC_W-1:0];
        tick_d[i]    = sum[i][ACC_W];
        clk_out_d[i] = sum[i][ACC_W-1];
        // Loading only on a wrap keeps the new rate phase-continuous.
        if (sum[i][ACC_W] && pend_q[i]) begin
          inc_d[i]  = pend_inc_q[i];
          pend_d[i] = 1'b0;
        end
      end
      // A request accepted on a wrap edge only becomes pending here, so it waits for the following wrap.
      if (cfg_accept && (cfg_ch == CH_W'(i))) begin
        pend_d[i]     = 1'b1;
        pend_inc_d[i] = cfg_inc;
      end
    end
  end

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (cfg_accept || (|pend_q)) begin
      lock_cnt_d = '0;
    end else if (lock_cnt_q != LOCK_MAX) begin
      lock_cnt_d = lock_cnt_q + 1'b1;
    end
    locked_d = (lock_cnt_q == LOCK_MAX) && !(|pend_q);
  end

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      acc_q      <= '0;
      inc_q      <= {N_CH{DEFAULT_INC}};
      pend_inc_q <= '0;
      pend_q     <= '0;
      tick_q     <= '0;
      clk_out_q  <= '0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      cfg_err_q  <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      inc_q      <= inc_d;
      pend_inc_q <= pend_inc_d;
      pend_q     <= pend_d;
      tick_q     <= tick_d;
      clk_out_q  <= clk_out_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      cfg_err_q  <= cfg_err_d;
      run_q      <= run_d;
    end
  end

  assign tick    = tick_q;
  assign clk_out = clk_out_q;
  assign locked  = locked_q;
  assign cfg_err = cfg_err_q;

endmodule
